data_mem_ws: RTL and testbench

DATA_MEM_WS -- requirements
Module: data_mem_ws

---
 rtl/dmem_pkg.sv | 15 +
 rtl/byte_merge.sv | 14 +
 rtl/data_mem_ws.sv | 151 +++++++++++++++
 tb/tb_data_mem_ws.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the wait-state data memory.
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BYTES  = 4;
    localparam int BYTE_W = 8;
    // Wide enough for a WAIT_CYCLES value of 0..15.
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;
endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge: lanes with byteen set take the new word, the rest keep the old word.
module byte_merge
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] i_old,
    input  logic [WORD_W-1:0] i_new,
    input  logic [BYTES-1:0]  i_byteen,
    output logic [WORD_W-1:0] o_merged
);
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        assign o_merged[BYTE_W*b +: BYTE_W] = i_byteen[b] ? i_new[BYTE_W*b +: BYTE_W]
                                                          : i_old[BYTE_W*b +: BYTE_W];
    end
endmodule

// File: rtl/data_mem_ws.sv
// Word-addressed data memory with a fixed response latency and a post-reset
// zero sweep. Optional write trace port is built when DMEM_TRACE_EN is defined;
// otherwise the trace outputs are tied to zero.
module data_mem_ws
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        trace_valid,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [31:0] trace_pc
);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [31:0]       SPAN     = 32'(4 * DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_clr_idx;
    logic [IDX_W-1:0]    r_idx;
    logic [WCNT_W-1:0]   r_cnt;
    logic                r_we;
    logic                r_in_range;
    logic [BYTES-1:0]    r_byteen;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic [31:0]         w_off;
    logic                w_in_range;
    logic                w_accept;
    logic                w_resp;
    logic                w_commit;
    logic [WORD_W-1:0]   w_old;
    logic [WORD_W-1:0]   w_merged;

    // Range check is done on the live address and frozen with the request.
    assign w_off      = addr - BASE_ADDR;
    assign w_in_range = (addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_accept   = (r_state == ST_IDLE) && req;
    assign w_resp     = (r_state == ST_RESP) && !reset;
    assign w_old      = r_mem[r_idx];
    // Zero byte enables change nothing, so they skip both the write and the trace.
    assign w_commit   = w_resp && r_we && r_in_range && (r_byteen != '0);

    byte_merge u_merge (
        .i_old    (w_old),
        .i_new    (r_wdata),
        .i_byteen (r_byteen),
        .o_merged (w_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (req) w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (r_cnt == WCNT_W'(1)) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Sweep index, wait counter and the request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_idx  <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            r_byteen   <= '0;
            r_wdata    <= '0;
        end else begin
            if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
            if (w_accept) begin
                r_cnt      <= WAIT_LD;
                r_idx      <= w_off[IDX_W+1:2];
                r_we       <= we;
                r_in_range <= w_in_range;
                r_byteen   <= byteen;
                r_wdata    <= wdata;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage: zero sweep after reset, merged write on the response edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) r_mem[r_clr_idx] <= '0;
            else if (w_commit)       r_mem[r_idx]     <= w_merged;
        end
    end

    assign ready = w_resp;
    assign err   = w_resp && !r_in_range;
    assign rdata = (w_resp && r_in_range) ? w_old : '0;
    assign busy  = (r_state == ST_CLEAR) && !reset;

`ifdef DMEM_TRACE_EN
    logic [29:0] r_addr_w;
    logic [31:0] r_pc;

    // Trace-only capture of the word address and issuing pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_w <= '0;
            r_pc     <= '0;
        end else if (w_accept) begin
            r_addr_w <= addr[31:2];
            r_pc     <= pc;
        end
    end

    assign trace_valid = w_commit;
    assign trace_addr  = w_commit ? {r_addr_w, 2'b00} : '0;
    assign trace_data  = w_commit ? w_merged : '0;
    assign trace_pc    = w_commit ? r_pc : '0;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
    assign trace_valid = 1'b0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
    assign trace_pc    = '0;
`endif
endmodule

// File: tb/tb_data_mem_ws.sv
// Bench for data_mem_ws: two instances (WAIT_CYCLES 2 and 0, DEPTH 16) checked
// against a word-array reference model.
module tb_data_mem_ws;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0, pc = '0;
    logic [3:0]  byteen = '0;

    logic        ready_a, err_a, busy_a, tv_a;
    logic [31:0] rdata_a, ta_a, td_a, tp_a;
    logic        ready_b, err_b, busy_b, tv_b;
    logic [31:0] rdata_b, ta_b, td_b, tp_b;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];

    always #5 clk = ~clk;

    data_mem_ws #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .byteen(byteen),
        .wdata(wdata), .pc(pc), .ready(ready_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .trace_valid(tv_a), .trace_addr(ta_a), .trace_data(td_a), .trace_pc(tp_a));

    data_mem_ws #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .byteen(byteen),
        .wdata(wdata), .pc(pc), .ready(ready_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .trace_valid(tv_b), .trace_addr(ta_b), .trace_data(td_b), .trace_pc(tp_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++)
            if (be[n]) r = (r & ~(32'hFF << (8 * n))) | (new_w & (32'hFF << (8 * n)));
        return r;
    endfunction

    // One access on instance A (sel_b=0) or B (sel_b=1); returns the sampled rdata.
    task automatic access(input bit sel_b, input logic w, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic [31:0] p, output logic [31:0] rd);
        int          lat;
        int          idx;
        bit          inr;
        bit          exp_tv;
        logic [31:0] old_w, merged;
        logic        rdy, e, tv;
        logic [31:0] ta, td, tp;
        inr    = (a < 32'(4 * DEPTH));
        idx    = inr ? int'(a[31:2]) : 0;
        old_w  = sel_b ? mem_b[idx] : mem_a[idx];
        merged = ref_merge(old_w, d, be);
        exp_tv = w && inr && (be != 4'b0);

        @(negedge clk);
        we = w; addr = a; byteen = be; wdata = d; pc = p;
        if (sel_b) req_b = 1'b1; else req_a = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            rdy = sel_b ? ready_b : ready_a;
        end while (!rdy && lat < 40);
        rd = sel_b ? rdata_b : rdata_a;
        e  = sel_b ? err_b : err_a;
        tv = sel_b ? tv_b : tv_a;
        ta = sel_b ? ta_b : ta_a;
        td = sel_b ? td_b : td_a;
        tp = sel_b ? tp_b : tp_a;
        req_a = 1'b0; req_b = 1'b0;

        chk("latency", lat, sel_b ? 1 : 3);
        chk("err", {31'b0, e}, {31'b0, !inr});
        if (!w || !inr) chk("rdata", rd, inr ? old_w : 32'h0);
`ifdef DMEM_TRACE_EN
        chk("trace_valid", {31'b0, tv}, {31'b0, exp_tv});
        if (exp_tv) begin
            chk("trace_addr", ta, {a[31:2], 2'b00});
            chk("trace_data", td, merged);
            chk("trace_pc", tp, p);
        end
`else
        chk("trace_tied", {31'b0, tv} | ta | td | tp, 32'h0);
`endif
        if (w && inr) begin
            if (sel_b) mem_b[idx] = merged; else mem_a[idx] = merged;
        end
        @(posedge clk); #1;
        chk("ready_pulse", {31'b0, sel_b ? ready_b : ready_a}, 32'h0);
    endtask

    // Reset for one cycle, check quiet outputs, then time the clear sweep.
    task automatic do_reset();
        int n;
        @(negedge clk);
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs", {26'b0, ready_a, err_a, busy_a, tv_a, ready_b, busy_b}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk("busy_len", n, DEPTH);
        chk("busy_b_done", {31'b0, busy_b}, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] b2b_addr [3];
        int          cyc, prev, n;
        bit          seen;

        // Sweep, then fresh memory reads zero.
        do_reset();
        access(0, 0, 32'h10, 4'h0, 32'h0, 32'h0, rd);
        chk("clear_read_0x10", rd, 32'h0);

        // Full-word write then read back.
        access(0, 1, 32'h20, 4'hF, 32'hDEADBEEF, 32'h100, rd);
        access(0, 0, 32'h20, 4'h0, 32'h0, 32'h104, rd);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        // Byte-lane merge.
        access(0, 1, 32'h20, 4'hF, 32'h11223344, 32'h108, rd);
        access(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h400, rd);
        access(0, 0, 32'h22, 4'h0, 32'h0, 32'h10C, rd);
        chk("rd_merge", rd, 32'h11BB33DD);

        // Zero byte enables leave the word alone.
        access(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h110, rd);
        access(0, 0, 32'h20, 4'h0, 32'h0, 32'h114, rd);
        chk("rd_be0", rd, 32'h11BB33DD);

        // Out of range write, then sweep all in-range words.
        access(0, 1, 32'h40, 4'hF, 32'hCAFEF00D, 32'h118, rd);
        for (int i = 0; i < DEPTH; i++) access(0, 0, 32'(4 * i), 4'h0, 32'h0, 32'h0, rd);

        // Random traffic, including unaligned and out-of-range addresses.
        for (int k = 0; k < 40; k++)
            access(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
                   4'($urandom), $urandom, $urandom, rd);

        // Back-to-back reads on the zero-wait instance with req held high.
        b2b_addr[0] = 32'h4; b2b_addr[1] = 32'h8; b2b_addr[2] = 32'hC;
        for (int k = 0; k < 3; k++) access(1, 1, b2b_addr[k], 4'hF, $urandom, 32'h200, rd);
        @(negedge clk);
        we = 1'b0; addr = b2b_addr[0]; req_b = 1'b1;
        cyc = 0; prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                cyc++; n++;
            end while (!ready_b && n < 20);
            chk("b2b_ready", {31'b0, ready_b}, 32'h1);
            chk("b2b_rdata", rdata_b, mem_b[b2b_addr[k][5:2]]);
            if (k > 0) chk("b2b_gap", cyc - prev, 2);
            prev = cyc;
            if (k < 2) addr = b2b_addr[k + 1];
            else       req_b = 1'b0;
        end

        // Reset during the wait of a write: abandoned, memory swept.
        access(0, 1, 32'h8, 4'hF, 32'h55, 32'h300, rd);
        @(negedge clk);
        we = 1'b1; addr = 32'h8; byteen = 4'hF; wdata = 32'h12345678; req_a = 1'b1;
        @(posedge clk); #1;
        seen = ready_a;
        do_reset();
        chk("abandon_no_ready", {31'b0, seen}, 32'h0);
        access(0, 0, 32'h8, 4'h0, 32'h0, 32'h0, rd);
        chk("abandon_rd", rd, 32'h0);

        // Reset mid-sweep restarts the full sweep.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid_sweep_busy", {31'b0, busy_a}, 32'h1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
